// File: rtl/dft_scan_scheduler.sv
// Scan-chain dump scheduler: serves every chain enabled in chain_mask in ascending index order.
// Optional watchdog abort is compiled in with `define DFT_SCHED_TIMEOUT_EN.
module dft_scan_scheduler #(
    parameter int unsigned p_sc_nbr  = 16,
    parameter int unsigned p_timeout = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [p_sc_nbr-1:0] chain_mask,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [p_sc_nbr-1:0] dft_val_op,
    input  logic [p_sc_nbr-1:0] dft_op_ack,
    input  logic [p_sc_nbr-1:0] dft_output_strobe,
    input  logic [p_sc_nbr-1:0] dft_op_commit,
    output logic [p_sc_nbr-1:0] dft_commit_ack,
    output logic                rf_wen,
    output logic [3:0]          rf_wr_idx,
    output logic [7:0]          word_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        CAPTURE,
        ACK,
        DONE
    } state_t;

    state_t state, next_state;

    logic [p_sc_nbr-1:0] pending;
    logic [p_sc_nbr-1:0] sel_oh;
    logic [p_sc_nbr-1:0] next_oh;
    logic [p_sc_nbr-1:0] val_op_nxt;
    logic [p_sc_nbr-1:0] commit_ack_nxt;
    logic [3:0]          low_idx;
    logic                busy_nxt;
    logic                done_nxt;
    logic                ack_sel;
    logic                strobe_sel;
    logic                commit_sel;
    logic                timeout;

    function automatic logic [p_sc_nbr-1:0] chain_onehot(input logic [3:0] idx);
        logic [p_sc_nbr-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < p_sc_nbr; i++) begin
            oh[i] = (idx == 4'(i));
        end
        return oh;
    endfunction

    // Scan from the top down so the lowest pending index is the last one written.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = p_sc_nbr; i > 0; i--) begin
            if (pending[i-1]) begin
                low_idx = 4'(i - 1);
            end
        end
    end

    assign sel_oh     = chain_onehot(rf_wr_idx);
    assign ack_sel    = |(dft_op_ack & sel_oh);
    assign strobe_sel = |(dft_output_strobe & sel_oh);
    assign commit_sel = |(dft_op_commit & sel_oh);

`ifdef DFT_SCHED_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(p_timeout - 1);

    logic [7:0] wd_cnt;
    logic       err_q;

    // An abort only fires in a cycle that makes no progress on the selected chain.
    assign timeout = (wd_cnt == WD_LAST) &&
                     (((state == REQ) && !ack_sel) ||
                      ((state == CAPTURE) && !commit_sel && !strobe_sel));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (((next_state == REQ) && (state != REQ)) ||
                     ((next_state == CAPTURE) && (state != CAPTURE)) ||
                     ((state == CAPTURE) && strobe_sel)) begin
            wd_cnt <= '0;
        end else if (((state == REQ) || (state == CAPTURE)) && (wd_cnt != 8'hFF)) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SELECT;
            SELECT:  next_state = (pending == '0) ? DONE : REQ;
            REQ: begin
                if (ack_sel) begin
                    next_state = CAPTURE;
                end else if (timeout) begin
                    next_state = SELECT;
                end
            end
            CAPTURE: begin
                if (commit_sel) begin
                    next_state = ACK;
                end else if (timeout) begin
                    next_state = SELECT;
                end
            end
            ACK:     next_state = SELECT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are computed from next_state so they line up with the state they belong to.
    always_comb begin
        rf_wen         = (state == CAPTURE) && strobe_sel;
        next_oh        = (state == SELECT) ? chain_onehot(low_idx) : sel_oh;
        val_op_nxt     = (next_state == REQ) ? next_oh : '0;
        commit_ack_nxt = (next_state == ACK) ? sel_oh : '0;
        busy_nxt       = (next_state != IDLE);
        done_nxt       = (next_state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dft_val_op     <= '0;
            dft_commit_ack <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            dft_val_op     <= val_op_nxt;
            dft_commit_ack <= commit_ack_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            rf_wr_idx <= '0;
            word_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending  <= chain_mask;
                        word_cnt <= '0;
                    end
                end
                SELECT: begin
                    if (pending != '0) begin
                        rf_wr_idx <= low_idx;
                        word_cnt  <= '0;
                    end
                end
                REQ: begin
                    if (timeout) begin
                        pending <= pending & ~sel_oh;
                    end
                end
                CAPTURE: begin
                    if (strobe_sel && (word_cnt != 8'hFF)) begin
                        word_cnt <= word_cnt + 8'd1;
                    end
                    if (timeout) begin
                        pending <= pending & ~sel_oh;
                    end
                end
                ACK: pending <= pending & ~sel_oh;
                default: ;
            endcase
        end
    end

endmodule
